// File: rtl/chord_pkg.sv
// Shared types and constants for the polyphonic chord mixer.
// Holds the mixer state encoding, note/duration widths and sizing helpers.
package chord_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCUM,
    OUT
  } mix_state_e;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  // Accumulator wide enough to sum every voice without wrapping.
  function automatic int acc_width(input int sample_w,
                                   input int voices);
    return sample_w + $clog2(voices);
  endfunction

  function automatic longint sat_max(input int sample_w);
    return (longint'(1) <<< (sample_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int sample_w);
    return -(longint'(1) <<< (sample_w - 1));
  endfunction

endpackage

// File: rtl/voice_allocator.sv
// Voice slot bookkeeping: busy mask, lowest-free pick,
// load strobe, acknowledge and sticky overflow.
module voice_allocator
  import chord_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  load_note,
  input  logic [NOTE_W-1:0]     note_in,
  input  logic [DUR_W-1:0]      dur_in,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic                  load_ack,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_dur,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  alloc_overflow
);

  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [NUM_VOICES-1:0] load_q, load_d;
  logic [NUM_VOICES-1:0] pick;
  logic [NOTE_W-1:0]     note_q, note_d;
  logic [DUR_W-1:0]      dur_q, dur_d;
  logic                  ack_q, ack_d;
  logic                  ovf_q, ovf_d;
  logic                  found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!busy_q[v] && !found) begin
        pick[v] = 1'b1;
        found   = 1'b1;
      end
    end
    busy_d = busy_q & ~voice_done;
    load_d = '0;
    ack_d  = 1'b0;
    note_d = note_q;
    dur_d  = dur_q;
    ovf_d  = ovf_q;
    if (play && load_note) begin
      ack_d = 1'b1;
      if (note_in != '0) begin
        if (found) begin
          load_d = pick;
          busy_d = busy_d | pick;
          note_d = note_in;
          dur_d  = dur_in;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      load_q <= '0;
      note_q <= '0;
      dur_q  <= '0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      load_q <= load_d;
      note_q <= note_d;
      dur_q  <= dur_d;
      ack_q  <= ack_d;
      ovf_q  <= ovf_d;
    end
  end

  assign load_ack       = ack_q;
  assign voice_load     = load_q;
  assign voice_note     = note_q;
  assign voice_dur      = dur_q;
  assign voice_busy     = busy_q;
  assign alloc_overflow = ovf_q;

endmodule

// File: rtl/poly_chord_mixer.sv
// Polyphonic chord player: voice allocation plus a sequential
// one-voice-per-cycle mixer with gain shift and saturation.
module poly_chord_mixer
  import chord_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_SHIFT = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           load_note,
  input  logic [NOTE_W-1:0]              note_in,
  input  logic [DUR_W-1:0]               dur_in,
  output logic                           load_ack,
  output logic [NUM_VOICES-1:0]          voice_load,
  output logic [NOTE_W-1:0]              voice_note,
  output logic [DUR_W-1:0]               voice_dur,
  input  logic [NUM_VOICES-1:0]          voice_done,
  output logic [NUM_VOICES-1:0]          voice_busy,
  output logic                           alloc_overflow,
  input  logic                           generate_next_sample,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_sample_ready,
  output logic signed [SAMPLE_W-1:0]     sample_out,
  output logic                           sample_ready,
  output logic                           timeout_flag
);

  localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'(sat_max(SAMPLE_W));
  localparam logic signed [ACC_W-1:0] SAT_LO =
    ACC_W'(sat_min(SAMPLE_W));

  voice_allocator #(
    .NUM_VOICES(NUM_VOICES)
  ) u_alloc (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .load_note     (load_note),
    .note_in       (note_in),
    .dur_in        (dur_in),
    .voice_done    (voice_done),
    .load_ack      (load_ack),
    .voice_load    (voice_load),
    .voice_note    (voice_note),
    .voice_dur     (voice_dur),
    .voice_busy    (voice_busy),
    .alloc_overflow(alloc_overflow)
  );

  mix_state_e                  state_q, state_d;
  logic [NUM_VOICES-1:0]       mask_q, mask_d;
  logic [NUM_VOICES-1:0]       rdy_q, rdy_d;
  logic signed [SAMPLE_W-1:0]  samp_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0]  samp_d [NUM_VOICES];
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [ACC_W-1:0]     term, shr;
  logic signed [SAMPLE_W-1:0]  out_q, out_d;
  logic                        srdy_q, srdy_d;
  logic                        to_q, to_d;
  logic                        lat_en;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    rdy_d   = rdy_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    srdy_d  = 1'b0;
    to_d    = to_q;
    term    = '0;
    shr     = '0;
    lat_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (generate_next_sample) begin
          mask_d  = voice_busy;
          rdy_d   = '0;
          cnt_d   = '0;
          lat_en  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_en = 1'b1;
        if ((rdy_q & mask_q) == mask_q) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          to_d    = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACCUM: begin
        term = {{(ACC_W-SAMPLE_W){samp_q[idx_q][SAMPLE_W-1]}},
                samp_q[idx_q]};
        if (mask_q[idx_q] && rdy_q[idx_q]) begin
          acc_d = acc_q + term;
        end
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        shr = acc_q >>> GAIN_SHIFT;
        if (!play) begin
          out_d = '0;
        end else if (shr > SAT_HI) begin
          out_d = SAT_HI[SAMPLE_W-1:0];
        end else if (shr < SAT_LO) begin
          out_d = SAT_LO[SAMPLE_W-1:0];
        end else begin
          out_d = shr[SAMPLE_W-1:0];
        end
        srdy_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ready latches OR in after the request clears them.
    if (lat_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_sample_ready[v]) begin
          samp_d[v] = voice_sample[v*SAMPLE_W +: SAMPLE_W];
          rdy_d[v]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      rdy_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      srdy_q  <= 1'b0;
      to_q    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        samp_q[v] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      srdy_q  <= srdy_d;
      to_q    <= to_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        samp_q[v] <= samp_d[v];
      end
    end
  end

  assign sample_out   = out_q;
  assign sample_ready = srdy_q;
  assign timeout_flag = to_q;

endmodule

// File: tb/tb_poly_chord_mixer.sv
// Bench for poly_chord_mixer: allocation sequences, table-driven
// mix vectors, timeout, silence and reset corner cases.
module tb_poly_chord_mixer;

  logic        clk;
  logic        reset;
  logic        play;
  logic        load_note;
  logic [5:0]  note_in;
  logic [5:0]  dur_in;
  logic [3:0]  voice_done;
  logic        gns;
  logic [63:0] voice_sample;
  logic [3:0]  vs_ready;

  logic        ack_a, ack_b;
  logic [3:0]  vload_a, vload_b;
  logic [5:0]  vnote_a, vnote_b;
  logic [5:0]  vdur_a, vdur_b;
  logic [3:0]  busy_a, busy_b;
  logic        ovf_a, ovf_b;
  logic signed [15:0] so_a, so_b;
  logic        sr_a, sr_b;
  logic        to_a, to_b;

  poly_chord_mixer #(
    .NUM_VOICES(4), .SAMPLE_W(16),
    .GAIN_SHIFT(2), .TIMEOUT(10)
  ) u_dut (
    .clk(clk), .reset(reset), .play(play),
    .load_note(load_note), .note_in(note_in), .dur_in(dur_in),
    .load_ack(ack_a), .voice_load(vload_a),
    .voice_note(vnote_a), .voice_dur(vdur_a),
    .voice_done(voice_done), .voice_busy(busy_a),
    .alloc_overflow(ovf_a), .generate_next_sample(gns),
    .voice_sample(voice_sample), .voice_sample_ready(vs_ready),
    .sample_out(so_a), .sample_ready(sr_a), .timeout_flag(to_a)
  );

  poly_chord_mixer #(
    .NUM_VOICES(4), .SAMPLE_W(16),
    .GAIN_SHIFT(0), .TIMEOUT(10)
  ) u_sat (
    .clk(clk), .reset(reset), .play(play),
    .load_note(load_note), .note_in(note_in), .dur_in(dur_in),
    .load_ack(ack_b), .voice_load(vload_b),
    .voice_note(vnote_b), .voice_dur(vdur_b),
    .voice_done(voice_done), .voice_busy(busy_b),
    .alloc_overflow(ovf_b), .generate_next_sample(gns),
    .voice_sample(voice_sample), .voice_sample_ready(vs_ready),
    .sample_out(so_b), .sample_ready(sr_b), .timeout_flag(to_b)
  );

  typedef struct {
    int s0; int s1; int s2; int s3;
    int e2; int e0;
  } vec_t;

  typedef struct {
    int e2; int e0; int t0; int lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[6];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sr_a || sr_b) begin
      if (sb.size() == 0) begin
        chk("unexpected_sample_ready", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ready_gs2", int'(sr_a), 1);
        chk("ready_gs0", int'(sr_b), 1);
        chk("mix_gs2", so_a, e.e2);
        chk("mix_gs0", so_b, e.e0);
        if (e.lat > 0) chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    load_note = 1'b1;
    note_in   = 6'(n);
    dur_in    = 6'd4;
    step();
    load_note = 1'b0;
  endtask

  task automatic request(input int s0, input int s1,
                         input int s2, input int s3,
                         input logic [3:0] rdy,
                         input int e2, input int e0,
                         input int lat);
    voice_sample = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    vs_ready     = rdy;
    gns          = 1'b1;
    sb.push_back('{e2, e0, cyc, lat});
    step();
    gns      = 1'b0;
    vs_ready = 4'b0000;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, sb.size(), 0);
    sb.delete();
    repeat (3) step();
  endtask

  initial begin
    tbl[0] = '{4000, -1000, 2000, 3000, 2000, 8000};
    tbl[1] = '{32767, 32767, 32767, 32767, 32767, 32767};
    tbl[2] = '{-32768, -32768, -32768, -32768, -32768, -32768};
    tbl[3] = '{100, -200, 300, -401, -51, -201};
    tbl[4] = '{1, 2, 3, -7, -1, -1};
    tbl[5] = '{20000, 20000, -5000, 0, 8750, 32767};

    reset        = 1'b1;
    play         = 1'b1;
    load_note    = 1'b0;
    note_in      = '0;
    dur_in       = '0;
    voice_done   = '0;
    gns          = 1'b0;
    voice_sample = '0;
    vs_ready     = '0;
    repeat (3) step();
    chk("rst_busy", busy_a, 0);
    chk("rst_ack", int'(ack_a), 0);
    chk("rst_load", vload_a, 0);
    chk("rst_ovf", int'(ovf_a), 0);
    chk("rst_out", so_a, 0);
    chk("rst_ready", int'(sr_a), 0);
    chk("rst_timeout", int'(to_a), 0);
    reset = 1'b0;
    step();

    begin
      int notes[4];
      notes = '{10, 12, 15, 17};
      for (int i = 0; i < 4; i++) begin
        load_note = 1'b1;
        note_in   = 6'(notes[i]);
        dur_in    = 6'd4;
        step();
        chk("alloc_load", vload_a, 1 << i);
        chk("alloc_ack", int'(ack_a), 1);
        chk("alloc_note", vnote_a, notes[i]);
      end
      load_note = 1'b0;
    end
    chk("alloc_dur", vdur_a, 4);
    chk("all_busy", busy_a, 4'b1111);
    chk("no_ovf", int'(ovf_a), 0);

    play = 1'b0;
    load(30);
    chk("play0_ack", int'(ack_a), 0);
    chk("play0_ovf", int'(ovf_a), 0);
    play = 1'b1;

    load(20);
    chk("full_ack", int'(ack_a), 1);
    chk("full_load", vload_a, 0);
    chk("full_ovf", int'(ovf_a), 1);
    voice_done = 4'b0100;
    step();
    voice_done = 4'b0000;
    chk("done_busy", busy_a, 4'b1011);
    load(22);
    chk("refill_load", vload_a, 4'b0100);
    chk("refill_note", vnote_a, 22);

    voice_done = 4'b0010;
    load(25);
    voice_done = 4'b0000;
    chk("same_cyc_load", vload_a, 0);
    chk("same_cyc_ack", int'(ack_a), 1);
    chk("same_cyc_busy", busy_a, 4'b1101);
    load(26);
    chk("next_cyc_load", vload_a, 4'b0010);
    chk("busy_full", busy_a, 4'b1111);

    for (int i = 0; i < 6; i++) begin
      request(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3,
              4'b1111, tbl[i].e2, tbl[i].e0, 7);
      wait_done("vec_drain");
    end
    chk("no_timeout_yet", int'(to_a), 0);

    play = 1'b0;
    request(4000, -1000, 2000, 3000, 4'b1111, 0, 0, 7);
    wait_done("play0_drain");
    play = 1'b1;

    voice_done = 4'b1100;
    step();
    voice_done = 4'b0000;
    chk("mask_0011", busy_a, 4'b0011);
    request(1000, 5555, 0, 0, 4'b0001, 250, 1000, 0);
    repeat (2) step();
    gns = 1'b1;
    step();
    gns = 1'b0;
    wait_done("timeout_drain");
    repeat (25) step();
    chk("timeout_flag", int'(to_a), 1);
    chk("timeout_flag_b", int'(to_b), 1);

    voice_done = 4'b0011;
    step();
    voice_done = 4'b0000;
    chk("mask_empty", busy_a, 0);
    request(7, 7, 7, 7, 4'b0000, 0, 0, 7);
    wait_done("empty_drain");
    request(900, 900, 900, 900, 4'b1111, 0, 0, 7);
    wait_done("empty_rdy_drain");

    load(40);
    chk("post_empty_load", vload_a, 4'b0001);
    voice_sample = 64'd123;
    vs_ready     = 4'b0000;
    gns          = 1'b1;
    step();
    gns = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    chk("midrst_busy", busy_a, 0);
    chk("midrst_timeout", int'(to_a), 0);
    chk("midrst_ovf", int'(ovf_a), 0);

    load(41);
    chk("postrst_load", vload_a, 4'b0001);
    request(800, 0, 0, 0, 4'b0001, 200, 800, 7);
    wait_done("postrst_drain");
    chk("held_out", so_a, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
